// File: rtl/text_console_writer.sv
// Text console writer: turns a stream of ASCII codes into character-buffer
// writes for a COLS x ROWS text display. It handles printable characters,
// LF, CR, BS and FF, clears the buffer after reset or on FF, and scrolls
// the buffer up by one row when the cursor leaves the last row.
//
// Buffer read timing: SCROLL_RD registers the source address. buf_rdata is
// sampled in the following SCROLL_WR cycle, one cycle after the read
// address was issued, and written to the destination address.
module text_console_writer #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        buf_we,
    output logic [11:0] buf_addr,
    output logic [7:0]  buf_wdata,
    input  logic [7:0]  buf_rdata,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);

    localparam int unsigned AW       = 12;
    localparam int unsigned RW       = 5;
    localparam int unsigned CW       = 7;
    localparam int unsigned CELLS    = ROWS * COLS;
    localparam int unsigned SCROLL_N = (ROWS - 1) * COLS;

    localparam logic [AW-1:0] LAST_CELL     = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_SCROLL   = AW'(SCROLL_N - 1);
    localparam logic [AW-1:0] LAST_CLR_IDX  = AW'(COLS - 1);
    localparam logic [AW-1:0] COLS_A        = AW'(COLS);
    localparam logic [AW-1:0] LAST_ROW_BASE = AW'(SCROLL_N);
    localparam logic [RW-1:0] LAST_ROW      = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL      = CW'(COLS - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CLEAR      = 3'd1;
    localparam logic [2:0] S_SCROLL_RD  = 3'd2;
    localparam logic [2:0] S_SCROLL_WR  = 3'd3;
    localparam logic [2:0] S_SCROLL_CLR = 3'd4;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_FIRST = 8'h20;
    localparam logic [7:0] CH_LAST  = 8'h7E;

    logic [2:0]    r_state;
    logic [AW-1:0] r_idx;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_wdata;
    logic          r_ready;
    logic          r_busy;

    logic [2:0]    w_nxt_state;
    logic [AW-1:0] w_nxt_idx;
    logic [RW-1:0] w_nxt_row;
    logic [CW-1:0] w_nxt_col;
    logic          w_nxt_we;
    logic [AW-1:0] w_nxt_addr;
    logic [7:0]    w_nxt_wdata;
    logic          w_nxt_ready;

    logic [AW-1:0] w_cell_addr;
    logic          w_printable;
    logic          w_last_row;
    logic          w_last_col;

    // Linear address of the cell under the cursor and character class decode
    always_comb begin
        w_cell_addr = (AW'(r_row) * COLS_A) + AW'(r_col);
        w_printable = (char_data >= CH_FIRST) && (char_data <= CH_LAST);
        w_last_row  = (r_row == LAST_ROW);
        w_last_col  = (r_col == LAST_COL);
    end

    // Next-state, cursor and buffer-port decode
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_row   = r_row;
        w_nxt_col   = r_col;
        w_nxt_we    = 1'b0;
        w_nxt_addr  = r_addr;
        w_nxt_wdata = r_wdata;

        case (r_state)
            S_IDLE: begin
                if (char_valid) begin
                    if (w_printable) begin
                        w_nxt_we    = 1'b1;
                        w_nxt_addr  = w_cell_addr;
                        w_nxt_wdata = char_data;
                        if (w_last_col) begin
                            w_nxt_col = '0;
                            if (w_last_row) begin
                                w_nxt_state = S_SCROLL_RD;
                                w_nxt_idx   = '0;
                            end else begin
                                w_nxt_row = r_row + RW'(1);
                            end
                        end else begin
                            w_nxt_col = r_col + CW'(1);
                        end
                    end else begin
                        case (char_data)
                            CH_LF: begin
                                w_nxt_col = '0;
                                if (w_last_row) begin
                                    w_nxt_state = S_SCROLL_RD;
                                    w_nxt_idx   = '0;
                                end else begin
                                    w_nxt_row = r_row + RW'(1);
                                end
                            end
                            CH_CR: begin
                                w_nxt_col = '0;
                            end
                            CH_BS: begin
                                // No reverse wrap: BS at column 0 does nothing
                                if (r_col != '0) begin
                                    w_nxt_col   = r_col - CW'(1);
                                    w_nxt_we    = 1'b1;
                                    w_nxt_addr  = w_cell_addr - AW'(1);
                                    w_nxt_wdata = CH_SPACE;
                                end
                            end
                            CH_FF: begin
                                w_nxt_row   = '0;
                                w_nxt_col   = '0;
                                w_nxt_state = S_CLEAR;
                                w_nxt_idx   = '0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end

            S_CLEAR: begin
                w_nxt_we    = 1'b1;
                w_nxt_addr  = r_idx;
                w_nxt_wdata = CH_SPACE;
                if (r_idx == LAST_CELL) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_idx   = '0;
                end else begin
                    w_nxt_idx = r_idx + AW'(1);
                end
            end

            S_SCROLL_RD: begin
                w_nxt_addr  = r_idx + COLS_A;
                w_nxt_state = S_SCROLL_WR;
            end

            S_SCROLL_WR: begin
                w_nxt_we    = 1'b1;
                w_nxt_addr  = r_idx;
                w_nxt_wdata = buf_rdata;
                if (r_idx == LAST_SCROLL) begin
                    w_nxt_state = S_SCROLL_CLR;
                    w_nxt_idx   = '0;
                end else begin
                    w_nxt_state = S_SCROLL_RD;
                    w_nxt_idx   = r_idx + AW'(1);
                end
            end

            S_SCROLL_CLR: begin
                w_nxt_we    = 1'b1;
                w_nxt_addr  = LAST_ROW_BASE + r_idx;
                w_nxt_wdata = CH_SPACE;
                if (r_idx == LAST_CLR_IDX) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_idx   = '0;
                end else begin
                    w_nxt_idx = r_idx + AW'(1);
                end
            end

            default: begin
                // Unreachable encodings recover through a full clear
                w_nxt_state = S_CLEAR;
                w_nxt_idx   = '0;
            end
        endcase

        w_nxt_ready = (w_nxt_state == S_IDLE);
    end

    // State, cursor and registered buffer-port outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= CH_SPACE;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_row   <= w_nxt_row;
            r_col   <= w_nxt_col;
            r_we    <= w_nxt_we;
            r_addr  <= w_nxt_addr;
            r_wdata <= w_nxt_wdata;
            r_ready <= w_nxt_ready;
            r_busy  <= ~w_nxt_ready;
        end
    end

    assign char_ready = r_ready;
    assign busy       = r_busy;
    assign buf_we     = r_we;
    assign buf_addr   = r_addr;
    assign buf_wdata  = r_wdata;
    assign cursor_row = r_row;
    assign cursor_col = r_col;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a character-buffer model.
module tb_text_console_writer;

    localparam int COLS     = 80;
    localparam int ROWS     = 30;
    localparam int CELLS    = COLS * ROWS;
    localparam int SCROLL_N = (ROWS - 1) * COLS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        buf_we;
    logic [11:0] buf_addr;
    logic [7:0]  buf_wdata;
    logic [7:0]  buf_rdata;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:CELLS-1];
    logic       preload_go   = 1'b0;
    logic       preload_done = 1'b0;

    always #5 clk = ~clk;

    text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_wdata  (buf_wdata),
        .buf_rdata  (buf_rdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37) + 11);
    endfunction

    // Buffer model: read data follows the registered address
    assign buf_rdata = (int'(buf_addr) < CELLS) ? mem[buf_addr] : 8'h00;

    // Buffer model writes, plus a one-shot fill with a known pattern
    always @(negedge clk) begin
        if (preload_go && !preload_done) begin
            for (int a = 0; a < CELLS; a++) mem[a] = pat(a);
            preload_done = 1'b1;
        end else if (buf_we && int'(buf_addr) < CELLS) begin
            mem[buf_addr] = buf_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!char_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) check({tag, "_timeout"}, 32'(char_ready), 32'd1);
    endtask

    // Offer one character at a negedge with char_ready=1; returns at the
    // negedge right after it was accepted
    task automatic send(input logic [7:0] c);
        wait_ready("send");
        char_valid = 1'b1;
        char_data  = c;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic clear_watch(input string tag);
        int n_wr = 0;
        int bad  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (buf_we) begin
                if (int'(buf_addr) != n_wr || buf_wdata !== 8'h20) bad++;
                n_wr++;
            end
            if (char_ready) break;
        end
        check({tag, "_wr_count"}, 32'(n_wr), 32'(CELLS));
        check({tag, "_wr_order"}, 32'(bad), 32'd0);
        check({tag, "_ready"}, 32'(char_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_row"}, 32'(cursor_row), 32'd0);
        check({tag, "_col"}, 32'(cursor_col), 32'd0);
    endtask

    initial begin
        int n_wr;
        int bad;
        int low;
        logic [7:0] exp_d;

        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_we", 32'(buf_we), 32'd0);
        check("rst_addr", 32'(buf_addr), 32'd0);
        check("rst_wdata", 32'(buf_wdata), 32'h20);
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_row", 32'(cursor_row), 32'd0);
        check("rst_col", 32'(cursor_col), 32'd0);
        rst_n = 1'b1;

        // Power-up clear: 2400 writes of 0x20 ascending, then ready
        clear_watch("init_clear");

        // "AB" back-to-back
        char_valid = 1'b1;
        char_data  = 8'h41;
        @(negedge clk);
        char_data = 8'h42;
        check("A_we", 32'(buf_we), 32'd1);
        check("A_addr", 32'(buf_addr), 32'd0);
        check("A_data", 32'(buf_wdata), 32'h41);
        check("A_ready", 32'(char_ready), 32'd1);
        check("A_col", 32'(cursor_col), 32'd1);
        @(negedge clk);
        char_valid = 1'b0;
        check("B_we", 32'(buf_we), 32'd1);
        check("B_addr", 32'(buf_addr), 32'd1);
        check("B_data", 32'(buf_wdata), 32'h42);
        check("B_row", 32'(cursor_row), 32'd0);
        check("B_col", 32'(cursor_col), 32'd2);

        // Column wrap without scroll: cursor (5,79), 'X'
        send(8'h0D);
        repeat (5) send(8'h0A);
        repeat (79) send(8'h61);
        check("pre_X_row", 32'(cursor_row), 32'd5);
        check("pre_X_col", 32'(cursor_col), 32'd79);
        send(8'h58);
        check("X_we", 32'(buf_we), 32'd1);
        check("X_addr", 32'(buf_addr), 32'd479);
        check("X_data", 32'(buf_wdata), 32'h58);
        check("X_row", 32'(cursor_row), 32'd6);
        check("X_col", 32'(cursor_col), 32'd0);
        check("X_no_scroll", 32'(char_ready), 32'd1);

        // FF clears and homes the cursor
        send(8'h0C);
        check("FF_busy", 32'(busy), 32'd1);
        check("FF_we", 32'(buf_we), 32'd0);
        clear_watch("ff_clear");

        // BS at col 0, CR, BEL: no writes, cursor stays (2,0)
        send(8'h0A);
        send(8'h0A);
        send(8'h08);
        check("BS0_we", 32'(buf_we), 32'd0);
        send(8'h0D);
        check("CR_we", 32'(buf_we), 32'd0);
        send(8'h07);
        check("BEL_we", 32'(buf_we), 32'd0);
        check("noop_row", 32'(cursor_row), 32'd2);
        check("noop_col", 32'(cursor_col), 32'd0);

        // BS at (2,4) blanks addr 163
        repeat (4) send(8'h70);
        send(8'h08);
        check("BS_we", 32'(buf_we), 32'd1);
        check("BS_addr", 32'(buf_addr), 32'd163);
        check("BS_data", 32'(buf_wdata), 32'h20);
        check("BS_row", 32'(cursor_row), 32'd2);
        check("BS_col", 32'(cursor_col), 32'd3);

        // Move to (29,3), fill buffer with a pattern, LF triggers a scroll
        repeat (27) send(8'h0A);
        check("row29_ready", 32'(char_ready), 32'd1);
        repeat (3) send(8'h71);
        check("pre_LF_row", 32'(cursor_row), 32'd29);
        check("pre_LF_col", 32'(cursor_col), 32'd3);
        preload_go = 1'b1;
        @(negedge clk);
        @(negedge clk);
        preload_go = 1'b0;

        char_valid = 1'b1;
        char_data  = 8'h0A;
        @(negedge clk);
        char_data = 8'h51;  // held during the scroll
        check("LF_ready", 32'(char_ready), 32'd0);
        check("LF_busy", 32'(busy), 32'd1);
        check("LF_we", 32'(buf_we), 32'd0);
        check("LF_row", 32'(cursor_row), 32'd29);
        check("LF_col", 32'(cursor_col), 32'd0);
        n_wr = 0;
        bad  = 0;
        low  = 1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            if (buf_we) begin
                exp_d = (n_wr < SCROLL_N) ? pat(n_wr + COLS) : 8'h20;
                if (int'(buf_addr) != n_wr || buf_wdata !== exp_d) bad++;
                n_wr++;
            end
            if (char_ready) break;
            low++;
        end
        check("scroll_busy_cycles", 32'(low), 32'(2 * SCROLL_N + COLS));
        check("scroll_wr_count", 32'(n_wr), 32'(CELLS));
        check("scroll_wr_order", 32'(bad), 32'd0);
        check("scroll_row", 32'(cursor_row), 32'd29);
        check("scroll_col", 32'(cursor_col), 32'd0);
        @(negedge clk);
        char_valid = 1'b0;
        check("held_we", 32'(buf_we), 32'd1);
        check("held_addr", 32'(buf_addr), 32'd2320);
        check("held_data", 32'(buf_wdata), 32'h51);
        check("held_col", 32'(cursor_col), 32'd1);

        // Reset 100 cycles into a second scroll
        send(8'h0A);
        check("scroll2_busy", 32'(busy), 32'd1);
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_we", 32'(buf_we), 32'd0);
        check("mid_rst_addr", 32'(buf_addr), 32'd0);
        check("mid_rst_ready", 32'(char_ready), 32'd0);
        check("mid_rst_row", 32'(cursor_row), 32'd0);
        rst_n = 1'b1;
        clear_watch("rst_clear");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
